instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader_if.sv | 28 ++
 rtl/instr_mem_loader.sv | 106 ++++++++++
 tb/tb_instr_mem_loader.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_if.sv
// Loader bus: instruction request handshake plus instruction-memory write port and status.
// slave = loader side, master = producer / memory side.
interface instr_mem_loader_if #(
    parameter int address_width  = 32,
    parameter int mem_addr_width = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic [address_width-1:0]  base;
    logic [address_width-1:0]  imm;
    logic                      ImmSrc;
    logic                      wr_en;
    logic [mem_addr_width-1:0] wr_addr;
    logic [address_width-1:0]  wr_data;
    logic [mem_addr_width:0]   count;
    logic                      full;
    logic                      err;

    modport slave (
        input  in_valid, base, imm, ImmSrc,
        output in_ready, wr_en, wr_addr, wr_data, count, full, err
    );

    modport master (
        output in_valid, base, imm, ImmSrc,
        input  in_ready, wr_en, wr_addr, wr_data, count, full, err
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Inserts an I/B-type immediate into a base instruction and writes it to sequential memory words.
// Latency: write one cycle after accept, one instruction per two cycles; in_ready drops while writing, when full or on clear.
module instr_mem_loader #(
    parameter int address_width  = 32,
    parameter int mem_addr_width = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    instr_mem_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

    localparam logic [mem_addr_width:0] depth_c = {1'b1, {mem_addr_width{1'b0}}};
    localparam logic [mem_addr_width:0] one_c   = {{mem_addr_width{1'b0}}, 1'b1};

    state_t                    state, state_nxt;
    logic [mem_addr_width:0]   cnt;
    logic                      err_q;
    logic [mem_addr_width-1:0] addr_q;
    logic [address_width-1:0]  data_q;
    logic [address_width-1:0]  enc;
    logic                      range_bad;
    logic                      rdy;
    logic                      wen;
    logic                      take;
    logic [mem_addr_width:0]   cnt_inc;

    assign cnt_inc   = cnt + one_c;
    assign range_bad = (bus.imm[address_width-1:12] != {(address_width-12){bus.imm[11]}});
    assign take      = bus.in_valid && rdy;

    always_comb begin
        enc = bus.base;
        if (bus.ImmSrc) begin
            enc[31:20] = bus.imm[11:0];
        end else begin
            enc[31]    = bus.imm[11];
            enc[7]     = bus.imm[10];
            enc[30:25] = bus.imm[9:4];
            enc[11:8]  = bus.imm[3:0];
        end
    end

    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        wen       = 1'b0;
        case (state)
            IDLE: begin
                rdy = !clear;
                if (bus.in_valid && !clear && !range_bad)
                    state_nxt = WRITE;
            end
            WRITE: begin
                // clear drops the pending write outright
                wen = !clear;
                if (clear)
                    state_nxt = IDLE;
                else if (cnt_inc == depth_c)
                    state_nxt = FULL;
                else
                    state_nxt = IDLE;
            end
            FULL: begin
                if (clear)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            err_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state <= state_nxt;
            if (clear) begin
                cnt   <= '0;
                err_q <= 1'b0;
            end else begin
                if (take && range_bad)
                    err_q <= 1'b1;
                if (wen)
                    cnt <= cnt_inc;
            end
            // Write address/data are captured at accept and held until the next legal accept.
            if (take && !range_bad) begin
                addr_q <= cnt[mem_addr_width-1:0];
                data_q <= enc;
            end
        end
    end

    assign bus.in_ready = rdy;
    assign bus.wr_en    = wen;
    assign bus.wr_addr  = addr_q;
    assign bus.wr_data  = data_q;
    assign bus.count    = cnt;
    assign bus.full     = (cnt == depth_c);
    assign bus.err      = err_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: encoding, range fault, fill, clear priority, async reset.
module tb_instr_mem_loader;
    logic clk;
    logic rst_n;
    logic clear;
    int   n_cmp;
    int   n_bad;

    instr_mem_loader_if #(.address_width(32), .mem_addr_width(8)) bus ();

    instr_mem_loader #(.address_width(32), .mem_addr_width(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] b, input logic [31:0] i, input logic src);
        bus.in_valid = 1'b1;
        bus.base     = b;
        bus.imm      = i;
        bus.ImmSrc   = src;
    endtask

    logic [31:0] d;
    logic [31:0] dec;
    logic [31:0] iv;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        clear = 1'b0;
        bus.in_valid = 1'b0;
        bus.base = '0;
        bus.imm = '0;
        bus.ImmSrc = 1'b0;
        step();
        step();
        chk("rst_wr_en",   bus.wr_en,   0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_count",   bus.count,   0);
        chk("rst_full",    bus.full,    0);
        chk("rst_err",     bus.err,     0);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", bus.in_ready, 1);

        // I-type
        drive(32'h0000_0013, 32'hFFFF_F800, 1'b1);
        step();
        bus.in_valid = 1'b0;
        chk("i_wr_en",   bus.wr_en,   1);
        chk("i_wr_addr", bus.wr_addr, 0);
        chk("i_wr_data", bus.wr_data, 32'h8000_0013);
        chk("i_ready_w", bus.in_ready, 0);
        step();
        chk("i_wr_en_off", bus.wr_en, 0);
        chk("i_count",     bus.count, 1);
        chk("i_hold_data", bus.wr_data, 32'h8000_0013);
        chk("i_ready",     bus.in_ready, 1);

        // B-type
        drive(32'h0000_0063, 32'h0000_07FF, 1'b0);
        step();
        bus.in_valid = 1'b0;
        chk("b_wr_en",   bus.wr_en,   1);
        chk("b_wr_addr", bus.wr_addr, 1);
        chk("b_wr_data", bus.wr_data, 32'h7E00_0FE3);
        d   = bus.wr_data;
        dec = {{20{d[31]}}, d[31], d[7], d[30:25], d[11:8]};
        chk("b_decode", dec, 32'h0000_07FF);
        step();
        chk("b_count", bus.count, 2);

        // range fault
        drive(32'h0000_0013, 32'h0000_1000, 1'b1);
        step();
        bus.in_valid = 1'b0;
        chk("rf_err",    bus.err,      1);
        chk("rf_wr_en",  bus.wr_en,    0);
        chk("rf_count",  bus.count,    2);
        chk("rf_ready",  bus.in_ready, 1);
        chk("rf_hold",   bus.wr_data,  32'h7E00_0FE3);

        // legal transfer after a fault
        drive(32'h0000_0093, 32'h0000_0005, 1'b1);
        step();
        bus.in_valid = 1'b0;
        chk("af_wr_en",   bus.wr_en,   1);
        chk("af_wr_addr", bus.wr_addr, 2);
        chk("af_wr_data", bus.wr_data, 32'h0050_0093);
        chk("af_err",     bus.err,     1);
        step();
        chk("af_count", bus.count, 3);

        // clear during WRITE
        drive(32'h0000_0013, 32'h0000_0001, 1'b1);
        step();
        bus.in_valid = 1'b0;
        clear = 1'b1;
        #1;
        chk("clr_w_wr_en", bus.wr_en,    0);
        chk("clr_w_ready", bus.in_ready, 0);
        step();
        clear = 1'b0;
        #1;
        chk("clr_w_count", bus.count,    0);
        chk("clr_w_err",   bus.err,      0);
        chk("clr_w_ready2", bus.in_ready, 1);

        // clear together with in_valid in IDLE
        drive(32'h0000_0013, 32'h0000_0002, 1'b1);
        clear = 1'b1;
        #1;
        chk("clr_i_ready", bus.in_ready, 0);
        step();
        clear = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("clr_i_wr_en", bus.wr_en, 0);
        chk("clr_i_count", bus.count, 0);

        // async reset mid-WRITE
        drive(32'h0000_0013, 32'h0000_2000, 1'b1);
        step();
        chk("ar_err_set", bus.err, 1);
        drive(32'h0000_0013, 32'h0000_0007, 1'b1);
        step();
        bus.in_valid = 1'b0;
        chk("ar_wr_en_pre", bus.wr_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_wr_en",   bus.wr_en,   0);
        chk("ar_wr_addr", bus.wr_addr, 0);
        chk("ar_wr_data", bus.wr_data, 0);
        chk("ar_count",   bus.count,   0);
        chk("ar_err",     bus.err,     0);
        step();
        rst_n = 1'b1;
        step();
        chk("ar_ready", bus.in_ready, 1);
        chk("ar_count_after", bus.count, 0);

        // fill all 256 words back-to-back
        for (int i = 0; i < 256; i++) begin
            iv = i;
            drive(32'h0000_0013, iv, 1'b1);
            step();
            chk("fill_wr_en",   bus.wr_en,   1);
            chk("fill_wr_addr", bus.wr_addr, iv[7:0]);
            chk("fill_wr_data", bus.wr_data, {iv[11:0], 20'h00013});
            step();
        end
        chk("fill_full",  bus.full,     1);
        chk("fill_ready", bus.in_ready, 0);
        chk("fill_count", bus.count,    256);
        drive(32'h0000_0013, 32'h0000_0009, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("full_no_wr", bus.wr_en, 0);
        end
        chk("full_count_hold", bus.count, 256);
        bus.in_valid = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        #1;
        chk("unfull_full",  bus.full,     0);
        chk("unfull_count", bus.count,    0);
        chk("unfull_ready", bus.in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
